// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with deferred I-miss redirect and perf counters
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [RA_W-1:0]   ex_rt,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              icache_stall,
    input  logic              dcache_stall,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {RUN, IMISS, IMISS_REDIR} state_t;

    state_t      state, state_nx;
    logic [31:0] pend_pc, pend_nx;
    logic        load_use;

    assign load_use = ex_memread && ex_rt != '0 &&
                      ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

    // state, pending redirect target, and saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nx;
            pend_pc <= pend_nx;
            if (perf_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (!pc_en && !(&stall_cnt))
                    stall_cnt <= stall_cnt + 1'b1;
                if (redirect_valid && !(&flush_cnt))
                    flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // per-cycle enables/flushes: dcache freeze beats load-use, which beats fetch/redirect handling
    always_comb begin
        pc_en          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_flush     = 1'b0;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        state_nx       = state;
        pend_nx        = pend_pc;
        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (dcache_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (icache_stall) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            if (branch_taken) begin
                pend_nx  = branch_target;
                state_nx = IMISS_REDIR;
            end else if (state == RUN) begin
                state_nx = IMISS;
            end
        end else if (state == IMISS_REDIR) begin
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc;
            ifid_flush     = 1'b1;
            state_nx       = RUN;
        end else begin
            state_nx = RUN;
            if (branch_taken) begin
                redirect_valid = 1'b1;
                redirect_pc    = branch_target;
                ifid_flush     = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_memread;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        icache_stall, dcache_stall, perf_clr;
    logic        pc_en, redirect_valid, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [31:0] rpc;
        logic [15:0] s;
        logic [15:0] f;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // ctl order: {pc_en, redirect_valid, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [7:0] NORM = 8'hAB;
    localparam logic [7:0] FRZ  = 8'h00;
    localparam logic [7:0] LU   = 8'h0F;
    localparam logic [7:0] BR   = 8'hFB;
    localparam logic [7:0] IST  = 8'h3B;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .perf_clr(perf_clr),
        .pc_en(pc_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // monitor: outputs are sampled mid-cycle and checked against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] ctl;
            e   = q.pop_front();
            ctl = {pc_en, redirect_valid, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
            n_chk++;
            if ({ctl, redirect_pc, stall_cnt, flush_cnt} !== {e.ctl, e.rpc, e.s, e.f}) begin
                n_fail++;
                $display("FAIL %s: got ctl=%h rpc=%h stall=%h flush=%h, expected ctl=%h rpc=%h stall=%h flush=%h",
                         e.name, ctl, redirect_pc, stall_cnt, flush_cnt, e.ctl, e.rpc, e.s, e.f);
            end
        end
    end

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        icache_stall = 1'b0; dcache_stall = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [7:0] ctl, input logic [31:0] rpc,
                       input logic [15:0] s, input logic [15:0] f);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.rpc = rpc; e.s = s; e.f = f;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", FRZ, 0, 0, 0);
        rst = 1'b0;
        cyc("idle", NORM, 0, 0, 0);
        // load-use via rs, then release
        ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
        cyc("load_use_rs", LU, 0, 0, 0);
        idle();
        cyc("lu_release", NORM, 0, 1, 0);
        // load-use via rt
        ex_memread = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1;
        cyc("load_use_rt", LU, 0, 1, 0);
        // r0 never hazards
        idle(); ex_memread = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
        cyc("lu_r0", NORM, 0, 2, 0);
        idle(); ex_memread = 1; ex_rt = 8; id_rs = 9; id_uses_rs = 1;
        cyc("lu_nomatch", NORM, 0, 2, 0);
        // branch in RUN
        idle(); branch_taken = 1; branch_target = 32'h40;
        cyc("branch_run", BR, 32'h40, 2, 0);
        idle();
        cyc("after_branch", NORM, 0, 2, 1);
        // branch during I-miss, replayed when miss ends
        icache_stall = 1; branch_taken = 1; branch_target = 32'h100;
        cyc("imiss_br1", IST, 0, 2, 1);
        branch_taken = 0; branch_target = 0;
        cyc("imiss_br2", IST, 0, 3, 1);
        cyc("imiss_br3", IST, 0, 4, 1);
        icache_stall = 0;
        cyc("imiss_replay", BR, 32'h100, 5, 1);
        cyc("imiss_run", NORM, 0, 5, 2);
        // plain miss, branch arrives later, youngest branch wins
        icache_stall = 1;
        cyc("imiss_plain", IST, 0, 5, 2);
        branch_taken = 1; branch_target = 32'h200;
        cyc("imiss_late_br", IST, 0, 6, 2);
        branch_target = 32'h300;
        cyc("imiss_youngest", IST, 0, 7, 2);
        idle();
        cyc("replay_youngest", BR, 32'h300, 8, 2);
        cyc("after_youngest", NORM, 0, 8, 3);
        // miss with no branch returns to normal advance
        icache_stall = 1;
        cyc("imiss_nobr", IST, 0, 8, 3);
        icache_stall = 0;
        cyc("imiss_end", NORM, 0, 9, 3);
        cyc("imiss_end_run", NORM, 0, 9, 3);
        // D-cache freeze over pending redirect
        icache_stall = 1; branch_taken = 1; branch_target = 32'h500;
        cyc("freeze_setup", IST, 0, 9, 3);
        idle(); dcache_stall = 1;
        cyc("freeze1", FRZ, 0, 10, 3);
        branch_taken = 1; branch_target = 32'h999;
        cyc("freeze2", FRZ, 0, 11, 3);
        idle();
        cyc("freeze_release", BR, 32'h500, 12, 3);
        cyc("freeze_run", NORM, 0, 12, 4);
        // dcache stall ignores branch in RUN
        dcache_stall = 1; branch_taken = 1; branch_target = 32'h600;
        cyc("dstall_br", FRZ, 0, 12, 4);
        idle();
        cyc("dstall_after", NORM, 0, 13, 4);
        // load-use beats branch
        ex_memread = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1; branch_taken = 1; branch_target = 32'h700;
        cyc("lu_over_br", LU, 0, 13, 4);
        idle();
        cyc("lu_over_br_after", NORM, 0, 14, 4);
        // saturate stall counter
        dcache_stall = 1;
        repeat (65530) @(posedge clk);
        #1;
        cyc("stall_sat", FRZ, 0, 16'hFFFF, 4);
        cyc("stall_hold", FRZ, 0, 16'hFFFF, 4);
        perf_clr = 1;
        cyc("perf_clr", FRZ, 0, 16'hFFFF, 4);
        idle();
        cyc("after_clr", NORM, 0, 0, 0);
        // async reset mid-miss discards pending redirect
        icache_stall = 1; branch_taken = 1; branch_target = 32'h800;
        cyc("rst_setup", IST, 0, 0, 0);
        idle(); icache_stall = 1; rst = 1;
        cyc("in_reset", FRZ, 0, 0, 0);
        rst = 0; icache_stall = 0;
        cyc("post_reset", NORM, 0, 0, 0);
        cyc("post_reset2", NORM, 0, 0, 0);
        @(posedge clk); #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether the PC and each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) advances, holds, or is loaded with a bubble.
- Resolves load-use hazards, ID-stage branch redirects, and I-/D-cache miss stalls.
- Latches a branch redirect that arrives during an I-cache miss and replays it when the miss ends; keeps stall/flush performance counters.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs  in  RA_W  source register rs of the instruction in ID
- id_rt  in  RA_W  source register rt of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  RA_W  load destination in EX
- branch_taken  in  1  ID branch/jump resolved taken
- branch_target  in  32  target address for branch_taken
- icache_stall  in  1  fetch not ready this cycle
- dcache_stall  in  1  memory stage not ready this cycle
- perf_clr  in  1  synchronous clear of the counters
- pc_en  out  1  PC register load enable
- redirect_valid  out  1  PC mux selects redirect_pc
- redirect_pc  out  32  next-PC redirect address
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a bubble (zero)
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads a bubble
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  branch redirects applied

Behaviour:
- State: FSM {RUN, IMISS, IMISS_REDIR}, plus pend_pc[31:0], stall_cnt, flush_cnt.
- Reset: state=RUN, pend_pc=0, counters=0.
- Outputs are combinational from state and inputs. While rst=1, all enables are 0 and all flushes, redirect_valid and redirect_pc are 0.
- Default outputs: every *_en=1, flushes=0, redirect_valid=0, redirect_pc=0.
- Load-use hazard, load_use: ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- Per-cycle priority: dcache_stall > load_use > redirect/icache handling.
- dcache_stall=1:
  - all enables 0, no flush, redirect_valid=0.
  - FSM and pend_pc hold; branch_taken ignored.
- load_use (no dcache_stall):
  - pc_en=0, ifid_en=0, idex_flush=1; exmem_en and memwb_en stay 1.
  - branch_taken ignored, since its operands are stale and it re-resolves next cycle.
  - FSM holds.
- RUN, icache_stall=0, branch_taken=1:
  - redirect_valid=1, redirect_pc=branch_target, ifid_flush=1.
  - flush_cnt increments.
- RUN, icache_stall=1:
  - pc_en=0, ifid_flush=1; ID/EX onward advance normally.
  - If branch_taken, latch pend_pc=branch_target and go to IMISS_REDIR; otherwise go to IMISS.
- IMISS:
  - While icache_stall=1: pc_en=0, ifid_flush=1.
  - If branch_taken arrives, latch pend_pc and go to IMISS_REDIR.
  - When icache_stall=0: normal advance, return to RUN.
- IMISS_REDIR:
  - While icache_stall=1: pc_en=0, ifid_flush=1.
  - When icache_stall=0: the fetched word is wrong-path. Drive redirect_valid=1, redirect_pc=pend_pc, ifid_flush=1, pc_en=1; flush_cnt increments; go to RUN.
  - A second branch_taken here overwrites pend_pc (youngest wins).
- ifid_flush overrides ifid_en; the register loads a bubble whenever ifid_flush=1.
- Counters:
  - stall_cnt increments every cycle rst=0 and pc_en=0.
  - Both counters saturate at all-ones and do not wrap.
  - perf_clr=1 zeroes both and takes priority over increment in that cycle.
- Asynchronous reset mid-miss discards pend_pc and any pending redirect immediately.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1; next cycle (ex_memread=0) all enables 1.
- Branch in RUN: branch_taken=1, branch_target=0x0000_0040 -> same cycle redirect_valid=1, redirect_pc=0x40, ifid_flush=1, pc_en=1; flush_cnt=1.
- Branch during I-miss: icache_stall=1 for 3 cycles, branch_taken=1 with target 0x100 in the first cycle -> 3 cycles of pc_en=0 and ifid_flush=1; cycle 4 (icache_stall=0) redirect_valid=1, redirect_pc=0x100, ifid_flush=1; then state RUN; stall_cnt=3, flush_cnt=1.
- D-cache freeze over I-miss: state IMISS_REDIR with dcache_stall=1 and icache_stall=0 for 2 cycles -> all enables 0, no redirect; redirect appears only in the first cycle after dcache_stall drops.
- Priority: load_use and branch_taken both 1 -> stall only, redirect_valid=0, flush_cnt unchanged.
- Counter edges: preload stall_cnt to 0xFFFF via a long stall -> holds 0xFFFF; perf_clr=1 with pc_en=0 -> both counters 0 next cycle. rst pulse in IMISS_REDIR -> state RUN with no redirect afterward.
